// File: rtl/lcd_char_writer.sv
// HD44780-style 4-bit LCD character writer.
// Runs the power-on init sequence, then accepts one byte at a time through a
// valid/ready handshake and sends it as two nibbles with the required timing.
module lcd_char_writer #(
  parameter int         T_POWERUP    = 750000,
  parameter int         T_INIT1      = 205000,
  parameter int         T_INIT2      = 5000,
  parameter int         T_INIT3      = 2000,
  parameter int         T_SETUP      = 2,
  parameter int         T_ENABLE     = 12,
  parameter int         T_NIBBLE_GAP = 50,
  parameter int         T_BYTE_GAP   = 2000,
  parameter int         T_CLEAR      = 82000,
  parameter logic [7:0] INIT_ENTRY   = 8'h06,
  parameter logic [7:0] INIT_DISPLAY = 8'h0C,
  parameter int         CNT_W        = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iValid,
  output logic       oReady,
  output logic       oInitDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);

  // A wait of T cycles ends on the cycle the counter reaches T-1; 0 acts as 1.
  function automatic logic [CNT_W-1:0] lastCount(input int t);
    if (t <= 1) return '0;
    return CNT_W'(t - 1);
  endfunction

  localparam logic [CNT_W-1:0] LAST_POWERUP = lastCount(T_POWERUP);
  localparam logic [CNT_W-1:0] LAST_INIT1   = lastCount(T_INIT1);
  localparam logic [CNT_W-1:0] LAST_INIT2   = lastCount(T_INIT2);
  localparam logic [CNT_W-1:0] LAST_INIT3   = lastCount(T_INIT3);
  localparam logic [CNT_W-1:0] LAST_SETUP   = lastCount(T_SETUP);
  localparam logic [CNT_W-1:0] LAST_ENABLE  = lastCount(T_ENABLE);
  localparam logic [CNT_W-1:0] LAST_NIBGAP  = lastCount(T_NIBBLE_GAP);
  localparam logic [CNT_W-1:0] LAST_BYTEGAP = lastCount(T_BYTE_GAP);
  localparam logic [CNT_W-1:0] LAST_CLEAR   = lastCount(T_CLEAR);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT_NIB, INIT_BYTE, IDLE, NIB_SETUP, NIB_EN, NIB_GAP, POST_WAIT
  } stateT;

  // Which kind of nibble the shared engine is currently sending.
  typedef enum logic [1:0] {NIB_SINGLE, NIB_HIGH, NIB_LOW} nibModeT;

  stateT            stateReg, stateNext;
  nibModeT          modeReg, modeNext;
  logic [CNT_W-1:0] cntReg;
  logic [7:0]       byteReg, byteNext;
  logic [2:0]       stepReg, stepNext;
  logic             rsReg, rsNext;
  logic [3:0]       dataReg, dataNext;
  logic             enReg, enNext;
  logic             readyReg, readyNext;
  logic             initDoneReg, initDoneNext;
  logic             rwReg, sfReg;
  logic             isClearCmd;
  logic [CNT_W-1:0] initGapLast;
  logic [7:0]       initByte;

  // Clear/home commands need the long post-byte wait.
  assign isClearCmd = !rsReg && (byteReg == 8'h01 || byteReg == 8'h02);

  // Wait after init nibble 1, 2, then 3 and 4.
  always_comb begin
    case (stepReg)
      3'd0:    initGapLast = LAST_INIT1;
      3'd1:    initGapLast = LAST_INIT2;
      default: initGapLast = LAST_INIT3;
    endcase
  end

  // Full init bytes, indexed by the low bits of the init step (steps 4..7).
  always_comb begin
    case (stepReg[1:0])
      2'd0:    initByte = 8'h28;
      2'd1:    initByte = INIT_ENTRY;
      2'd2:    initByte = INIT_DISPLAY;
      default: initByte = 8'h01;
    endcase
  end

  // Next-state and next-output logic; outputs are registered from these.
  always_comb begin
    stateNext    = stateReg;
    modeNext     = modeReg;
    byteNext     = byteReg;
    stepNext     = stepReg;
    rsNext       = rsReg;
    dataNext     = dataReg;
    initDoneNext = initDoneReg;
    case (stateReg)
      PWR_WAIT: begin
        if (cntReg >= LAST_POWERUP) stateNext = INIT_NIB;
      end
      INIT_NIB: begin
        rsNext    = 1'b0;
        modeNext  = NIB_SINGLE;
        dataNext  = (stepReg == 3'd3) ? 4'h2 : 4'h3;
        stateNext = NIB_SETUP;
      end
      INIT_BYTE: begin
        rsNext    = 1'b0;
        modeNext  = NIB_HIGH;
        byteNext  = initByte;
        dataNext  = initByte[7:4];
        stateNext = NIB_SETUP;
      end
      IDLE: begin
        if (iValid) begin
          rsNext    = iRS;
          modeNext  = NIB_HIGH;
          byteNext  = iData;
          dataNext  = iData[7:4];
          stateNext = NIB_SETUP;
        end
      end
      NIB_SETUP: begin
        if (cntReg >= LAST_SETUP) stateNext = NIB_EN;
      end
      NIB_EN: begin
        if (cntReg >= LAST_ENABLE) stateNext = (modeReg == NIB_LOW) ? POST_WAIT : NIB_GAP;
      end
      NIB_GAP: begin
        if (modeReg == NIB_HIGH) begin
          if (cntReg >= LAST_NIBGAP) begin
            modeNext  = NIB_LOW;
            dataNext  = byteReg[3:0];
            stateNext = NIB_SETUP;
          end
        end else if (cntReg >= initGapLast) begin
          stepNext  = stepReg + 3'd1;
          stateNext = (stepReg == 3'd3) ? INIT_BYTE : INIT_NIB;
        end
      end
      POST_WAIT: begin
        if (cntReg >= (isClearCmd ? LAST_CLEAR : LAST_BYTEGAP)) begin
          if (initDoneReg) begin
            stateNext = IDLE;
          end else if (stepReg == 3'd7) begin
            initDoneNext = 1'b1;
            stateNext    = IDLE;
          end else begin
            stepNext  = stepReg + 3'd1;
            stateNext = INIT_BYTE;
          end
        end
      end
      default: stateNext = PWR_WAIT;
    endcase
    enNext    = (stateNext == NIB_EN);
    readyNext = (stateNext == IDLE);
  end

  // State, control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg    <= PWR_WAIT;
      modeReg     <= NIB_SINGLE;
      byteReg     <= '0;
      stepReg     <= '0;
      rsReg       <= 1'b0;
      dataReg     <= '0;
      enReg       <= 1'b0;
      readyReg    <= 1'b0;
      initDoneReg <= 1'b0;
      rwReg       <= 1'b0;
      sfReg       <= 1'b1;
    end else begin
      stateReg    <= stateNext;
      modeReg     <= modeNext;
      byteReg     <= byteNext;
      stepReg     <= stepNext;
      rsReg       <= rsNext;
      dataReg     <= dataNext;
      enReg       <= enNext;
      readyReg    <= readyNext;
      initDoneReg <= initDoneNext;
      rwReg       <= 1'b0;
      sfReg       <= 1'b1;
    end
  end

  // Wait counter: restarts on every state change and saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntReg <= '0;
    end else if (stateNext != stateReg) begin
      cntReg <= '0;
    end else if (cntReg != '1) begin
      cntReg <= cntReg + CNT_W'(1);
    end
  end

  assign oReady                  = readyReg;
  assign oInitDone               = initDoneReg;
  assign oLCD_Enabled            = enReg;
  assign oLCD_RegisterSelect     = rsReg;
  assign oLCD_ReadWrite          = rwReg;
  assign oLCD_StrataFlashControl = sfReg;
  assign oLCD_Data               = dataReg;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Self-checking bench for lcd_char_writer with shortened timing parameters.
module tb_lcd_char_writer;

  localparam int T_POWERUP = 100, T_INIT1 = 40, T_INIT2 = 20, T_INIT3 = 10;
  localparam int T_SETUP = 2, T_ENABLE = 4, T_NIBBLE_GAP = 5, T_BYTE_GAP = 8, T_CLEAR = 30;
  localparam int NV = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] iData;
  logic       iRS;
  logic       iValid;
  logic       oReady, oInitDone, oLCD_Enabled, oLCD_RegisterSelect;
  logic       oLCD_ReadWrite, oLCD_StrataFlashControl;
  logic [3:0] oLCD_Data;

  lcd_char_writer #(
    .T_POWERUP(T_POWERUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_INIT3(T_INIT3),
    .T_SETUP(T_SETUP), .T_ENABLE(T_ENABLE), .T_NIBBLE_GAP(T_NIBBLE_GAP),
    .T_BYTE_GAP(T_BYTE_GAP), .T_CLEAR(T_CLEAR), .INIT_ENTRY(8'h06),
    .INIT_DISPLAY(8'h0C), .CNT_W(20)
  ) dut (
    .clk(clk), .rst(rst), .iData(iData), .iRS(iRS), .iValid(iValid),
    .oReady(oReady), .oInitDone(oInitDone), .oLCD_Enabled(oLCD_Enabled),
    .oLCD_RegisterSelect(oLCD_RegisterSelect), .oLCD_ReadWrite(oLCD_ReadWrite),
    .oLCD_StrataFlashControl(oLCD_StrataFlashControl), .oLCD_Data(oLCD_Data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         rise;
    int         fall;
    logic [3:0] nib;
    logic       rs;
  } pulseT;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    logic [3:0] expHi;
    logic [3:0] expLo;
    int         expWait;
  } vecT;

  pulseT      pulseQ[$];
  vecT        vec[NV];
  logic [3:0] initNibs[12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
  int         nChecks = 0;
  int         nErrors = 0;
  logic       ePrev = 1'b0;
  int         riseCyc = 0;
  logic [3:0] riseNib = '0;
  logic       riseRs = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nErrors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkGe(input string name, input int actual, input int minimum);
    nChecks++;
    if (actual < minimum) begin
      nErrors++;
      $display("FAIL %s: got %0d, expected at least %0d", name, actual, minimum);
    end
  endtask

  // One clock cycle: sample at the falling edge, check constant pins, track E pulses.
  task automatic tick();
    @(negedge clk);
    check("rw_low", int'(oLCD_ReadWrite), 0);
    check("sf_high", int'(oLCD_StrataFlashControl), 1);
    if (oLCD_Enabled && !ePrev) begin
      riseCyc = cyc;
      riseNib = oLCD_Data;
      riseRs  = oLCD_RegisterSelect;
    end else if (oLCD_Enabled && ePrev) begin
      check("nib_stable_during_e", int'(oLCD_Data), int'(riseNib));
      check("rs_stable_during_e", int'(oLCD_RegisterSelect), int'(riseRs));
    end else if (!oLCD_Enabled && ePrev) begin
      pulseQ.push_back('{riseCyc, cyc, riseNib, riseRs});
    end
    ePrev = oLCD_Enabled;
  endtask

  task automatic waitReady(input int bound);
    int n = 0;
    while (!oReady && n < bound) begin
      tick();
      n++;
    end
    check("ready_wait", int'(oReady), 1);
  endtask

  task automatic waitPulses(input int count, input int bound);
    int n = 0;
    while (pulseQ.size() < count && n < bound) begin
      tick();
      n++;
    end
    check("pulse_count", pulseQ.size(), count);
  endtask

  // Wait for init to complete and check the 12 init pulses.
  task automatic checkInit(input int relCyc);
    int n = 0;
    while (!oInitDone && n < 3000) begin
      tick();
      n++;
    end
    check("init_done", int'(oInitDone), 1);
    check("ready_with_init_done", int'(oReady), 1);
    check("init_pulse_count", pulseQ.size(), 12);
    if (pulseQ.size() >= 12) begin
      checkGe("powerup_quiet", pulseQ[0].rise - relCyc, T_POWERUP);
      for (int i = 0; i < 12; i++) begin
        check("init_nibble", int'(pulseQ[i].nib), int'(initNibs[i]));
        check("init_rs", int'(pulseQ[i].rs), 0);
        check("init_e_width", pulseQ[i].fall - pulseQ[i].rise, T_ENABLE);
      end
      checkGe("init_gap1", pulseQ[1].rise - pulseQ[0].fall, T_INIT1 + T_SETUP);
      checkGe("init_gap2", pulseQ[2].rise - pulseQ[1].fall, T_INIT2 + T_SETUP);
      checkGe("init_gap3", pulseQ[3].rise - pulseQ[2].fall, T_INIT3 + T_SETUP);
      checkGe("init_gap4", pulseQ[4].rise - pulseQ[3].fall, T_INIT3 + T_SETUP);
      for (int i = 4; i < 12; i += 2)
        check("init_nibble_gap", pulseQ[i+1].rise - pulseQ[i].fall, T_NIBBLE_GAP + T_SETUP);
      checkGe("init_done_delay", cyc - pulseQ[11].fall, T_CLEAR);
    end
  endtask

  initial begin
    int accCyc, readyCyc, relCyc, n;

    vec[0] = '{8'h41, 1'b1, 4'h4, 4'h1, T_BYTE_GAP};
    vec[1] = '{8'h01, 1'b0, 4'h0, 4'h1, T_CLEAR};
    vec[2] = '{8'h80, 1'b0, 4'h8, 4'h0, T_BYTE_GAP};
    vec[3] = '{8'h02, 1'b0, 4'h0, 4'h2, T_CLEAR};
    vec[4] = '{8'h01, 1'b1, 4'h0, 4'h1, T_BYTE_GAP};
    vec[5] = '{8'h03, 1'b0, 4'h0, 4'h3, T_BYTE_GAP};
    vec[6] = '{8'hFF, 1'b1, 4'hF, 4'hF, T_BYTE_GAP};

    rst = 1'b1; iData = '0; iRS = 1'b0; iValid = 1'b0;
    repeat (3) tick();
    check("rst_e", int'(oLCD_Enabled), 0);
    check("rst_rs", int'(oLCD_RegisterSelect), 0);
    check("rst_data", int'(oLCD_Data), 0);
    check("rst_ready", int'(oReady), 0);
    check("rst_init_done", int'(oInitDone), 0);

    pulseQ.delete();
    rst = 1'b0;
    relCyc = cyc;
    checkInit(relCyc);

    // Table of single writes: nibble order, RS, setup latency, gaps and post-wait.
    for (int i = 0; i < NV; i++) begin
      waitReady(400);
      pulseQ.delete();
      accCyc = cyc;
      iData = vec[i].data; iRS = vec[i].rs; iValid = 1'b1;
      tick();
      iValid = 1'b0; iData = ~vec[i].data; iRS = ~vec[i].rs;
      check("ready_low_after_accept", int'(oReady), 0);
      waitPulses(2, 200);
      n = 0;
      while (!oReady && n < 200) begin
        tick();
        n++;
      end
      readyCyc = cyc;
      check("ready_back", int'(oReady), 1);
      if (pulseQ.size() >= 2) begin
        check("hi_nibble", int'(pulseQ[0].nib), int'(vec[i].expHi));
        check("lo_nibble", int'(pulseQ[1].nib), int'(vec[i].expLo));
        check("hi_rs", int'(pulseQ[0].rs), int'(vec[i].rs));
        check("lo_rs", int'(pulseQ[1].rs), int'(vec[i].rs));
        check("e_rise_latency", pulseQ[0].rise - accCyc, T_SETUP + 1);
        check("nibble_gap", pulseQ[1].rise - pulseQ[0].fall, T_NIBBLE_GAP + T_SETUP);
        check("post_wait", readyCyc - pulseQ[1].fall, vec[i].expWait);
      end
      $display("write data=%h rs=%0d pulses=%0d ready_after=%0d", vec[i].data, vec[i].rs,
               pulseQ.size(), readyCyc - accCyc);
    end

    // iValid held with changed data during a write: not queued, next byte taken at ready.
    waitReady(400);
    pulseQ.delete();
    iData = 8'h41; iRS = 1'b1; iValid = 1'b1;
    tick();
    iData = 8'h55; iRS = 1'b0;
    n = 0;
    while (!oReady && n < 200) begin
      tick();
      n++;
    end
    readyCyc = cyc;
    check("held_ready_back", int'(oReady), 1);
    check("held_inflight_pulses", pulseQ.size(), 2);
    iData = 8'h33; iRS = 1'b1;
    tick();
    iValid = 1'b0;
    check("back_to_back_accept", int'(oReady), 0);
    waitPulses(4, 200);
    if (pulseQ.size() >= 4) begin
      check("held_hi", int'(pulseQ[0].nib), 4);
      check("held_lo", int'(pulseQ[1].nib), 1);
      check("next_hi", int'(pulseQ[2].nib), 3);
      check("next_lo", int'(pulseQ[3].nib), 3);
      check("next_rs", int'(pulseQ[2].rs), 1);
      check("next_rise", pulseQ[2].rise - readyCyc, T_SETUP + 1);
    end
    waitReady(200);
    repeat (60) tick();
    check("no_queued_byte", pulseQ.size(), 4);
    $display("held-valid sequence pulses=%0d", pulseQ.size());

    // Reset during E-high of a data write.
    waitReady(400);
    iData = 8'h48; iRS = 1'b1; iValid = 1'b1;
    tick();
    iValid = 1'b0;
    n = 0;
    while (!oLCD_Enabled && n < 50) begin
      tick();
      n++;
    end
    check("e_high_before_reset", int'(oLCD_Enabled), 1);
    #1 rst = 1'b1;
    #1;
    check("async_e_drop", int'(oLCD_Enabled), 0);
    check("async_ready", int'(oReady), 0);
    check("async_init_done", int'(oInitDone), 0);
    check("async_rs", int'(oLCD_RegisterSelect), 0);
    check("async_data", int'(oLCD_Data), 0);
    repeat (3) tick();
    check("held_rst_e", int'(oLCD_Enabled), 0);
    pulseQ.delete();
    rst = 1'b0;
    relCyc = cyc;
    checkInit(relCyc);
    $display("reset-mid-write sequence init pulses=%0d", pulseQ.size());

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
